// File: rtl/acl_hdr_pkg.sv
// Shared types and constants for the RX header parser and the ACL lookup stage it feeds.
package acl_hdr_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_TCP  = 8'd6;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam int unsigned HDR_WORDS_DEF = 10;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [7:0]  proto;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] sport;
    logic [15:0] dport;
    logic        supported;
  } acl_hdr_t;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StPresent,
    StWaitDone
  } parser_state_t;

  // Only option-less IPv4 carrying TCP or UDP has trustworthy L3/L4 field offsets.
  function automatic logic is_supported(input logic [15:0] ethertype,
                                        input logic [3:0]  version,
                                        input logic [3:0]  ihl,
                                        input logic [7:0]  proto);
    return (ethertype == ETH_TYPE_IPV4) && (version == 4'd4) && (ihl == 4'd5) &&
           ((proto == IP_PROTO_TCP) || (proto == IP_PROTO_UDP));
  endfunction

endpackage

// File: rtl/hdr_word_capture.sv
// Aligns FIFO read data with the delayed pop strobe and slices header words into record fields.
module hdr_word_capture
  import acl_hdr_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned HDR_WORDS  = HDR_WORDS_DEF,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              rd_valid_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output acl_hdr_t          raw_hdr_o,
  output logic [3:0]        version_o,
  output logic [3:0]        ihl_o
);

  localparam int unsigned IdxW = $clog2(HDR_WORDS);

  logic [RD_LATENCY-1:0] strobe_q;
  logic [IdxW-1:0]       idx_q;
  logic                  cap;

  assign cap = strobe_q[RD_LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      strobe_q  <= '0;
      idx_q     <= '0;
      raw_hdr_o <= '0;
      version_o <= '0;
      ihl_o     <= '0;
    end else if (clear_i) begin
      strobe_q <= '0;
      idx_q    <= '0;
    end else begin
      strobe_q[0] <= rd_valid_i;
      for (int i = 1; i < int'(RD_LATENCY); i++) strobe_q[i] <= strobe_q[i-1];
      if (cap && (int'(idx_q) < int'(HDR_WORDS))) begin
        idx_q <= idx_q + IdxW'(1);
        case (int'(idx_q))
          0: raw_hdr_o.dst_mac[47:16] <= fifo_data_i[31:0];
          1: begin
            raw_hdr_o.dst_mac[15:0]  <= fifo_data_i[31:16];
            raw_hdr_o.src_mac[47:32] <= fifo_data_i[15:0];
          end
          2: raw_hdr_o.src_mac[31:0] <= fifo_data_i[31:0];
          3: begin
            raw_hdr_o.ethertype <= fifo_data_i[31:16];
            version_o           <= fifo_data_i[15:12];
            ihl_o               <= fifo_data_i[11:8];
          end
          5: raw_hdr_o.proto <= fifo_data_i[7:0];
          6: raw_hdr_o.src_ip[31:16] <= fifo_data_i[15:0];
          7: begin
            raw_hdr_o.src_ip[15:0]  <= fifo_data_i[31:16];
            raw_hdr_o.dst_ip[31:16] <= fifo_data_i[15:0];
          end
          8: begin
            raw_hdr_o.dst_ip[15:0] <= fifo_data_i[31:16];
            raw_hdr_o.sport        <= fifo_data_i[15:0];
          end
          9: raw_hdr_o.dport <= fifo_data_i[31:16];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/eth_hdr_parser.sv
// Pops one L2/L3/L4 header per frame from the RX FIFO and presents it as an ACL record.
module eth_hdr_parser
  import acl_hdr_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 9,
  parameter int unsigned HDR_WORDS  = HDR_WORDS_DEF,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_fifo_data,
  input  logic [CNT_W-1:0]  i_fifo_wr_cnt,
  output logic              o_rd_valid,
  input  logic              i_frame_done,
  input  logic              i_flush,
  output logic              o_hdr_valid,
  input  logic              i_hdr_ready,
  output acl_hdr_t          o_hdr,
  output logic              o_busy
);

  localparam int unsigned IssueW = $clog2(HDR_WORDS);
  localparam int unsigned DrainW = $clog2(RD_LATENCY + 1);

  parser_state_t     state_q;
  logic [IssueW-1:0] issue_q;
  logic [DrainW-1:0] drain_q;
  acl_hdr_t          raw_hdr;
  acl_hdr_t          hdr_next;
  logic [3:0]        version;
  logic [3:0]        ihl;
  logic              cap_clear;

  // Idle clears the capture index so every frame starts at word 0; flush drops in-flight words.
  assign cap_clear = i_flush || (state_q == StIdle);
  assign o_busy    = (state_q != StIdle);

  hdr_word_capture #(
    .DATA_W    (DATA_W),
    .HDR_WORDS (HDR_WORDS),
    .RD_LATENCY(RD_LATENCY)
  ) u_capture (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clear_i    (cap_clear),
    .rd_valid_i (o_rd_valid),
    .fifo_data_i(i_fifo_data),
    .raw_hdr_o  (raw_hdr),
    .version_o  (version),
    .ihl_o      (ihl)
  );

  always_comb begin
    hdr_next           = raw_hdr;
    hdr_next.supported = is_supported(raw_hdr.ethertype, version, ihl, raw_hdr.proto);
    if (!hdr_next.supported) begin
      hdr_next.src_ip = '0;
      hdr_next.dst_ip = '0;
      hdr_next.sport  = '0;
      hdr_next.dport  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      issue_q     <= '0;
      drain_q     <= '0;
      o_rd_valid  <= 1'b0;
      o_hdr_valid <= 1'b0;
      o_hdr       <= '0;
    end else if (i_flush) begin
      state_q     <= StIdle;
      issue_q     <= '0;
      drain_q     <= '0;
      o_rd_valid  <= 1'b0;
      o_hdr_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_fifo_wr_cnt >= CNT_W'(HDR_WORDS)) begin
            state_q    <= StRead;
            o_rd_valid <= 1'b1;
            issue_q    <= '0;
          end
        end
        StRead: begin
          if (issue_q == IssueW'(HDR_WORDS - 1)) begin
            state_q    <= StDrain;
            o_rd_valid <= 1'b0;
            drain_q    <= '0;
          end else begin
            issue_q <= issue_q + IssueW'(1);
          end
        end
        StDrain: begin
          // Last word lands RD_LATENCY cycles after its pop; load the record one cycle later.
          if (drain_q == DrainW'(RD_LATENCY)) begin
            state_q     <= StPresent;
            o_hdr_valid <= 1'b1;
            o_hdr       <= hdr_next;
          end else begin
            drain_q <= drain_q + DrainW'(1);
          end
        end
        StPresent: begin
          if (i_hdr_ready) begin
            state_q     <= StWaitDone;
            o_hdr_valid <= 1'b0;
          end
        end
        StWaitDone: begin
          if (i_frame_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
